upload_frame_packer: RTL and testbench
======================================

# upload_frame_packer

Transmit-side framer for the USB upload path. It is the counterpart of the command-frame receiver in `cdc`. A client module supplies a command code, a payload length and a payload byte stream. The block emits one complete response frame as a valid/ready byte stream suitable for the USB CDC upload input:

- `0xAA 0x55 CMD LEN_H LEN_L PAYLOAD[0..LEN-1] CSUM`
- The frame carries backpressure taken from the endpoint FIFO almost-full flag.

## Interface

Parameters:
- `MAX_LEN`, default 256: largest accepted payload length in bytes; legal range 1..65535.

Ports:
- `clk` in 1: single clock; all logic is in this domain.
- `rst` in 1: asynchronous, active-high reset.
- `frame_start` in 1: request to start a frame; sampled only while `busy`=0.
- `frame_cmd` in 8: command byte; captured on an accepted `frame_start`.
- `frame_len` in 16: payload length; captured on an accepted `frame_start`.
- `busy` out 1: high from the cycle after an accepted start until the frame completes.
- `pl_data` in 8: payload byte.
- `pl_valid` in 1: payload byte valid.
- `pl_ready` out 1: the packer consumes `pl_data` on a cycle where `pl_valid` & `pl_ready`.
- `upload_data` out 8: framed output byte.
- `upload_valid` out 1: output byte valid.
- `upload_ready` in 1: sink accepts the byte; top level drives it with `~dc_fifo_afull`.
- `frame_done` out 1: one-cycle pulse on the cycle the CSUM byte is accepted.
- `len_error` out 1: one-cycle pulse when a start is rejected.

## Operation

- States: IDLE, HDR0, HDR1, CMD, LENH, LENL, PAYLOAD, CSUM.
- IDLE:
  - `frame_start`=1 with 1 ≤ `frame_len` ≤ `MAX_LEN`: latch cmd and len, clear the checksum, remaining count = len, go to HDR0.
  - `frame_len`=0 or `frame_len` > `MAX_LEN`: pulse `len_error` next cycle and stay in IDLE. No bytes are emitted and `busy` stays 0.
- Header bytes:
  - HDR0 emits 0xAA, then HDR1 emits 0x55, CMD emits the cmd byte, LENH emits len[15:8], LENL emits len[7:0].
  - Each state advances only on the handshake `upload_valid` & `upload_ready`.
  - LENL always advances to PAYLOAD, because length 0 is rejected in IDLE.
- Output register:
  - `upload_data`/`upload_valid` form a single output register.
  - While `upload_valid`=1 and `upload_ready`=0, `upload_data` holds stable and `upload_valid` stays high (no retraction).
- PAYLOAD:
  - `pl_ready` = (state==PAYLOAD) & (`upload_valid`=0 | `upload_ready`=1).
  - On a consumed payload byte, the byte is loaded into the output register with valid, added to the checksum, and the count is decremented.
  - When the last byte is consumed (count 1→0), go to CSUM.
  - `pl_valid` low inserts bubbles: `upload_valid` drops after the pending byte is accepted.
- Checksum: 8-bit sum modulo 256 of CMD, LEN_H, LEN_L and all payload bytes. The header bytes 0xAA and 0x55 are excluded.
- CSUM: emit the checksum byte. On its handshake, pulse `frame_done` and return to IDLE.
- `frame_start` while `busy`=1: ignored, with no effect on the current frame.
- Reset (asynchronous, any state, including mid-frame):
  - State goes to IDLE; the partial frame is abandoned with no trailer.
  - `busy`, `pl_ready`, `upload_valid`, `frame_done`, `len_error` = 0; `upload_data` = 0x00; checksum and counter = 0.

## Timing

- An accepted `frame_start` at cycle T gives `busy`=1 and `upload_valid`=1 with 0xAA at T+1.
- With `upload_ready` and `pl_valid` held high, one byte is emitted per cycle: a frame of length N occupies cycles T+1 .. T+N+6.
- `frame_done` pulses in the CSUM handshake cycle. `busy` is 0 from the next cycle, and a new `frame_start` can be accepted in that cycle, so back-to-back frames have a one-cycle gap.
- Payload latency: a payload byte consumed in cycle C appears on `upload_data` in cycle C+1.
- `pl_ready` is combinational from `upload_ready` and the state. It has no combinational path from `pl_valid`.
- `len_error` is registered: a rejected start at T pulses `len_error` at T+1.

## Test plan

- Basic frame: cmd=0x12, len=3, payload 01 02 03, ready always high → bytes AA 55 12 00 03 01 02 03 1B on 9 consecutive cycles; `frame_done` on the 1B cycle.
- Backpressure: same frame with `upload_ready` low for 4 cycles while 0x55 is presented → 0x55 held stable with valid high; the sequence resumes unchanged; `pl_ready` stays low during the stall.
- Payload bubbles and checksum wrap: cmd=0xFF, len=2, payload FF FF with `pl_valid` toggling → checksum (0xFF+0x00+0x02+0xFF+0xFF)&0xFF = 0xFF; the byte order is preserved.
- Length limits: `MAX_LEN`=256, start with len=257 or len=0 → `len_error` pulse, no output, `busy`=0; len=256 → 262-byte frame with LEN bytes 01 00.
- Start while busy: second `frame_start` (cmd=0x34) during the first frame's payload → ignored; only the first frame is output.
- Reset mid-frame: assert `rst` during PAYLOAD → all outputs 0 immediately. A subsequent start produces a complete, correct frame beginning with 0xAA.

Source files
------------

// File: rtl/upload_frame_packer.sv
// Response framer for the USB upload path: AA 55 CMD LEN_H LEN_L PAYLOAD CSUM on a valid/ready byte stream.
// The state names the field to load into the output register next; an accepted start loads 0xAA directly.
module upload_frame_packer #(
   parameter int MAX_LEN = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        frame_start,
   input  logic [7:0]  frame_cmd,
   input  logic [15:0] frame_len,
   output logic        busy,
   input  logic [7:0]  pl_data,
   input  logic        pl_valid,
   output logic        pl_ready,
   output logic [7:0]  upload_data,
   output logic        upload_valid,
   input  logic        upload_ready,
   output logic        frame_done,
   output logic        len_error
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      HDR0    = 3'd1,
      HDR1    = 3'd2,
      CMD     = 3'd3,
      LENH    = 3'd4,
      LENL    = 3'd5,
      PAYLOAD = 3'd6,
      CSUM    = 3'd7
   } state_t;

   localparam logic [15:0] MAX_LEN_C = 16'(MAX_LEN);

   function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
      return acc + b;
   endfunction

   state_t      state_q, state_d;
   logic [7:0]  cmd_q, cmd_d;
   logic [15:0] len_q, len_d;
   logic [15:0] cnt_q, cnt_d;
   logic [7:0]  csum_q, csum_d;
   logic [7:0]  data_q, data_d;
   logic        valid_q, valid_d;
   logic        busy_q, busy_d;
   logic        len_err_q, len_err_d;
   logic        tail_q, tail_d;

   logic        can_load_s;
   logic        hs_s;
   logic        pl_ready_s;
   logic        pl_take_s;
   logic        done_s;

   assign can_load_s = ~valid_q | upload_ready;
   assign hs_s       = valid_q & upload_ready;
   assign pl_ready_s = (state_q == PAYLOAD) & can_load_s;
   assign pl_take_s  = pl_ready_s & pl_valid;
   // tail_q marks that the checksum byte itself is in the output register
   assign done_s     = (state_q == CSUM) & tail_q & hs_s;

   // Next-state, output-register and checksum computation
   always_comb begin
      state_d   = state_q;
      cmd_d     = cmd_q;
      len_d     = len_q;
      cnt_d     = cnt_q;
      csum_d    = csum_q;
      data_d    = data_q;
      valid_d   = valid_q & ~upload_ready;
      busy_d    = busy_q;
      len_err_d = 1'b0;
      tail_d    = tail_q;
      case (state_q)
         IDLE: begin
            if (frame_start) begin
               if ((frame_len != 16'd0) && (frame_len <= MAX_LEN_C)) begin
                  cmd_d   = frame_cmd;
                  len_d   = frame_len;
                  cnt_d   = frame_len;
                  csum_d  = 8'h00;
                  data_d  = 8'hAA;
                  valid_d = 1'b1;
                  busy_d  = 1'b1;
                  tail_d  = 1'b0;
                  state_d = HDR1;
               end else begin
                  len_err_d = 1'b1;
               end
            end else begin
               state_d = IDLE;
            end
         end
         HDR0: begin
            if (can_load_s) begin
               data_d  = 8'hAA;
               valid_d = 1'b1;
               state_d = HDR1;
            end else begin
               state_d = HDR0;
            end
         end
         HDR1: begin
            if (can_load_s) begin
               data_d  = 8'h55;
               valid_d = 1'b1;
               state_d = CMD;
            end else begin
               state_d = HDR1;
            end
         end
         CMD: begin
            if (can_load_s) begin
               data_d  = cmd_q;
               valid_d = 1'b1;
               csum_d  = csum_add(csum_q, cmd_q);
               state_d = LENH;
            end else begin
               state_d = CMD;
            end
         end
         LENH: begin
            if (can_load_s) begin
               data_d  = len_q[15:8];
               valid_d = 1'b1;
               csum_d  = csum_add(csum_q, len_q[15:8]);
               state_d = LENL;
            end else begin
               state_d = LENH;
            end
         end
         LENL: begin
            if (can_load_s) begin
               data_d  = len_q[7:0];
               valid_d = 1'b1;
               csum_d  = csum_add(csum_q, len_q[7:0]);
               state_d = PAYLOAD;
            end else begin
               state_d = LENL;
            end
         end
         PAYLOAD: begin
            if (pl_take_s) begin
               data_d  = pl_data;
               valid_d = 1'b1;
               csum_d  = csum_add(csum_q, pl_data);
               cnt_d   = cnt_q - 16'd1;
               if (cnt_q == 16'd1) begin
                  state_d = CSUM;
               end else begin
                  state_d = PAYLOAD;
               end
            end else begin
               state_d = PAYLOAD;
            end
         end
         CSUM: begin
            if (!tail_q) begin
               if (can_load_s) begin
                  data_d  = csum_q;
                  valid_d = 1'b1;
                  tail_d  = 1'b1;
               end else begin
                  tail_d  = 1'b0;
               end
            end else if (hs_s) begin
               tail_d  = 1'b0;
               busy_d  = 1'b0;
               state_d = IDLE;
            end else begin
               state_d = CSUM;
            end
         end
         default: begin
            state_d = IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            tail_d  = 1'b0;
         end
      endcase
   end

   // State and output registers with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cmd_q     <= 8'h00;
         len_q     <= 16'h0000;
         cnt_q     <= 16'h0000;
         csum_q    <= 8'h00;
         data_q    <= 8'h00;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         len_err_q <= 1'b0;
         tail_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cmd_q     <= cmd_d;
         len_q     <= len_d;
         cnt_q     <= cnt_d;
         csum_q    <= csum_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         busy_q    <= busy_d;
         len_err_q <= len_err_d;
         tail_q    <= tail_d;
      end
   end

   assign busy         = busy_q;
   assign pl_ready     = pl_ready_s;
   assign upload_data  = data_q;
   assign upload_valid = valid_q;
   assign frame_done   = done_s;
   assign len_error    = len_err_q;

endmodule

// File: tb/tb_upload_frame_packer.sv
// Directed bench for upload_frame_packer: framing, backpressure, bubbles, length limits, busy starts, reset.
module tb_upload_frame_packer;

   logic        clk;
   logic        rst;
   logic        frame_start;
   logic [7:0]  frame_cmd;
   logic [15:0] frame_len;
   logic        busy;
   logic [7:0]  pl_data;
   logic        pl_valid;
   logic        pl_ready;
   logic [7:0]  upload_data;
   logic        upload_valid;
   logic        upload_ready;
   logic        frame_done;
   logic        len_error;

   int          checks;
   int          errors;
   int          cyc;
   int          t0;
   int          done_cnt;
   int          done_cyc;
   int          bubbles;
   int          pl_idx;
   logic [7:0]  pl_buf[$];
   logic [7:0]  got[$];
   int          got_cyc[$];
   logic [7:0]  exp_q[$];

   upload_frame_packer #(.MAX_LEN(256)) dut (
      .clk          (clk),
      .rst          (rst),
      .frame_start  (frame_start),
      .frame_cmd    (frame_cmd),
      .frame_len    (frame_len),
      .busy         (busy),
      .pl_data      (pl_data),
      .pl_valid     (pl_valid),
      .pl_ready     (pl_ready),
      .upload_data  (upload_data),
      .upload_valid (upload_valid),
      .upload_ready (upload_ready),
      .frame_done   (frame_done),
      .len_error    (len_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Sample just before the edge, advance one clock, then present the next payload byte.
   task automatic tick();
      #1;
      if (upload_valid && upload_ready) begin
         got.push_back(upload_data);
         got_cyc.push_back(cyc);
      end
      if (frame_done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (busy && !upload_valid) bubbles++;
      if (pl_valid && pl_ready) pl_idx++;
      @(posedge clk);
      #1;
      cyc++;
      pl_data = (pl_idx < pl_buf.size()) ? pl_buf[pl_idx] : 8'h00;
   endtask

   task automatic load_payload(input logic [7:0] b[$]);
      pl_buf = b;
      pl_idx = 0;
      pl_data = pl_buf[0];
      got.delete();
      got_cyc.delete();
      bubbles = 0;
   endtask

   task automatic start_frame(input logic [7:0] cmd, input logic [15:0] len);
      frame_cmd = cmd;
      frame_len = len;
      frame_start = 1'b1;
      t0 = cyc;
      tick();
      frame_start = 1'b0;
   endtask

   task automatic run_done(input string tag, input int budget, input bit toggle);
      int n;
      int d0;
      n = 0;
      d0 = done_cnt;
      while (done_cnt == d0 && n < budget) begin
         if (toggle) pl_valid = ~pl_valid;
         tick();
         n++;
      end
      chk({tag, "_done_seen"}, 32'(done_cnt - d0), 32'd1);
   endtask

   task automatic chk_frame(input string tag, input logic [7:0] e[$]);
      chk({tag, "_nbytes"}, 32'(got.size()), 32'(e.size()));
      for (int i = 0; i < e.size() && i < got.size(); i++)
         chk($sformatf("%s_b%0d", tag, i), 32'(got[i]), 32'(e[i]));
   endtask

   initial begin
      checks = 0; errors = 0; cyc = 0; done_cnt = 0; done_cyc = 0; bubbles = 0; pl_idx = 0;
      rst = 1'b1; frame_start = 1'b0; frame_cmd = 8'h00; frame_len = 16'h0000;
      pl_data = 8'h00; pl_valid = 1'b1; upload_ready = 1'b1;
      #2;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_valid", 32'(upload_valid), 32'd0);
      chk("rst_data", 32'(upload_data), 32'h00);
      chk("rst_pl_ready", 32'(pl_ready), 32'd0);
      chk("rst_done", 32'(frame_done), 32'd0);
      chk("rst_len_error", 32'(len_error), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Basic frame
      load_payload('{8'h01, 8'h02, 8'h03});
      start_frame(8'h12, 16'd3);
      chk("basic_busy_t1", 32'(busy), 32'd1);
      chk("basic_valid_t1", 32'(upload_valid), 32'd1);
      chk("basic_data_t1", 32'(upload_data), 32'hAA);
      run_done("basic", 40, 1'b0);
      exp_q = '{8'hAA, 8'h55, 8'h12, 8'h00, 8'h03, 8'h01, 8'h02, 8'h03, 8'h1B};
      chk_frame("basic", exp_q);
      if (got_cyc.size() == 9) begin
         chk("basic_first_cycle", 32'(got_cyc[0] - t0), 32'd1);
         chk("basic_last_cycle", 32'(got_cyc[8] - t0), 32'd9);
         chk("basic_done_on_csum", 32'(done_cyc - t0), 32'd9);
      end else begin
         chk("basic_byte_count_for_timing", 32'(got_cyc.size()), 32'd9);
      end
      chk("basic_no_bubbles", 32'(bubbles), 32'd0);
      chk("basic_busy_after", 32'(busy), 32'd0);

      // Backpressure while 0x55 is presented
      load_payload('{8'h01, 8'h02, 8'h03});
      start_frame(8'h12, 16'd3);
      tick();
      upload_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("stall%0d_data", i), 32'(upload_data), 32'h55);
         chk($sformatf("stall%0d_valid", i), 32'(upload_valid), 32'd1);
         #1;
         chk($sformatf("stall%0d_pl_ready", i), 32'(pl_ready), 32'd0);
         tick();
      end
      upload_ready = 1'b1;
      run_done("stall", 40, 1'b0);
      chk_frame("stall", exp_q);
      if (got_cyc.size() == 9) chk("stall_last_cycle", 32'(got_cyc[8] - t0), 32'd13);
      else chk("stall_byte_count_for_timing", 32'(got_cyc.size()), 32'd9);

      // Payload bubbles and checksum wrap
      load_payload('{8'hFF, 8'hFF});
      pl_valid = 1'b0;
      start_frame(8'hFF, 16'd2);
      run_done("bubble", 60, 1'b1);
      pl_valid = 1'b1;
      exp_q = '{8'hAA, 8'h55, 8'hFF, 8'h00, 8'h02, 8'hFF, 8'hFF, 8'hFF};
      chk_frame("bubble", exp_q);
      chk("bubble_seen", 32'(bubbles != 0), 32'd1);

      // Length limits
      load_payload('{8'h00});
      start_frame(8'h77, 16'd257);
      chk("len257_error", 32'(len_error), 32'd1);
      chk("len257_busy", 32'(busy), 32'd0);
      chk("len257_valid", 32'(upload_valid), 32'd0);
      tick();
      chk("len257_error_pulse", 32'(len_error), 32'd0);
      start_frame(8'h77, 16'd0);
      chk("len0_error", 32'(len_error), 32'd1);
      chk("len0_busy", 32'(busy), 32'd0);
      tick();
      chk("len0_no_output", 32'(got.size()), 32'd0);

      pl_buf.delete();
      for (int i = 0; i < 256; i++) pl_buf.push_back(8'(i));
      load_payload(pl_buf);
      start_frame(8'h5A, 16'd256);
      run_done("len256", 400, 1'b0);
      chk("len256_nbytes", 32'(got.size()), 32'd262);
      if (got.size() == 262) begin
         chk("len256_lenh", 32'(got[3]), 32'h01);
         chk("len256_lenl", 32'(got[4]), 32'h00);
         chk("len256_first_pl", 32'(got[5]), 32'h00);
         chk("len256_last_pl", 32'(got[260]), 32'hFF);
         chk("len256_csum", 32'(got[261]), 32'hDB);
         chk("len256_span", 32'(got_cyc[261] - got_cyc[0]), 32'd261);
      end else begin
         chk("len256_frame_shape", 32'(got.size()), 32'd262);
      end

      // Start while busy is ignored
      load_payload('{8'h01, 8'h02, 8'h03});
      start_frame(8'h12, 16'd3);
      for (int i = 0; i < 20 && got.size() < 6; i++) tick();
      frame_cmd = 8'h34;
      frame_len = 16'd1;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      run_done("busy_start", 40, 1'b0);
      exp_q = '{8'hAA, 8'h55, 8'h12, 8'h00, 8'h03, 8'h01, 8'h02, 8'h03, 8'h1B};
      chk_frame("busy_start", exp_q);
      got.delete();
      for (int i = 0; i < 5; i++) tick();
      chk("busy_start_no_second", 32'(got.size()), 32'd0);
      chk("busy_start_idle", 32'(busy), 32'd0);

      // Reset in the middle of the payload
      load_payload('{8'h01, 8'h02, 8'h03});
      start_frame(8'h12, 16'd3);
      for (int i = 0; i < 20 && got.size() < 6; i++) tick();
      rst = 1'b1;
      #1;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_valid", 32'(upload_valid), 32'd0);
      chk("midrst_data", 32'(upload_data), 32'h00);
      chk("midrst_pl_ready", 32'(pl_ready), 32'd0);
      chk("midrst_done", 32'(frame_done), 32'd0);
      tick();
      rst = 1'b0;
      load_payload('{8'h40});
      start_frame(8'h21, 16'd1);
      run_done("postrst", 40, 1'b0);
      exp_q = '{8'hAA, 8'h55, 8'h21, 8'h00, 8'h01, 8'h40, 8'h62};
      chk_frame("postrst", exp_q);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
